// File: rtl/elevator_req_queue_if.sv
// Request/position/target bundle for the elevator request queue.
// The master side is the button decoder plus car controller; the slave side is the queue.
interface elevator_req_queue_if #(
  parameter int LVL_W = 2
);
  logic             pressed_en;
  logic [LVL_W-1:0] pressed_lvl;
  logic             pos_valid;
  logic [LVL_W-1:0] pos_lvl;
  logic             target_valid;
  logic [LVL_W-1:0] target_lvl;
  logic             stop_at_pos_lvl;

  modport master (
    output pressed_en, pressed_lvl,
    output pos_valid, pos_lvl,
    input  target_valid, target_lvl,
    input  stop_at_pos_lvl
  );

  modport slave (
    input  pressed_en, pressed_lvl,
    input  pos_valid, pos_lvl,
    output target_valid, target_lvl,
    output stop_at_pos_lvl
  );
endinterface

// File: rtl/elevator_req_queue.sv
// Registered in-order floor request queue with dedup and at-floor removal.
// Optional drop counter (drop_cnt/drop_clr) is built when ELEVQ_DROP_CNT_EN is defined.
module elevator_req_queue #(
  parameter int NUM_LVL = 4,
  parameter int LVL_W   = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  elevator_req_queue_if.slave bus,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic [NUM_LVL-1:0] lvl_in_queue
`ifdef ELEVQ_DROP_CNT_EN
  ,
  input  logic               drop_clr,
  output logic [7:0]         drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [LVL_W:0]   NUM_C   = (LVL_W+1)'(NUM_LVL);

  logic [LVL_W-1:0] ent_q [DEPTH];
  logic [LVL_W-1:0] ent_d [DEPTH];
  logic [LVL_W-1:0] ext   [DEPTH+1];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_rm;
  logic             stop_q;
  logic             stop_d;
  logic             seen;
  logic             dup;
  logic             absorb;
  logic             in_rng;
  logic             accept;

  // Next state: remove the at-floor entry, then append an accepted press.
  always_comb begin
    seen = 1'b0;
    dup  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ext[i] = ent_q[i];
    end
    ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.pos_valid && (CNT_W'(i) < cnt_q)
          && (ent_q[i] == bus.pos_lvl)) begin
        seen = 1'b1;
      end
      ent_d[i] = seen ? ext[i+1] : ent_q[i];
    end
    cnt_rm = cnt_q - CNT_W'(seen);
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_rm)
          && (ent_d[i] == bus.pressed_lvl)) begin
        dup = 1'b1;
      end
    end
    absorb = bus.pressed_en && bus.pos_valid
             && (bus.pressed_lvl == bus.pos_lvl);
    in_rng = {1'b0, bus.pressed_lvl} < NUM_C;
    accept = bus.pressed_en && in_rng && !dup
             && !absorb && (cnt_rm < DEPTH_C);
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (CNT_W'(i) == cnt_rm)) begin
        ent_d[i] = bus.pressed_lvl;
      end
    end
    cnt_d  = cnt_rm + CNT_W'(accept);
    stop_d = seen || absorb;
  end

  // Queue storage, count and stop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q  <= '0;
      stop_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      cnt_q  <= cnt_d;
      stop_q <= stop_d;
    end
  end

  // Floor bitmap from the valid part of the stored entries.
  always_comb begin
    lvl_in_queue = '0;
    for (int j = 0; j < NUM_LVL; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < cnt_q) && (ent_q[i] == LVL_W'(j))) begin
          lvl_in_queue[j] = 1'b1;
        end
      end
    end
  end

  assign count               = cnt_q;
  assign full                = (cnt_q == DEPTH_C);
  assign empty               = (cnt_q == '0);
  assign bus.target_valid    = (cnt_q != '0);
  assign bus.target_lvl      = ent_q[0];
  assign bus.stop_at_pos_lvl = stop_q;

`ifdef ELEVQ_DROP_CNT_EN
  logic       drop_inc;
  logic [7:0] drop_q;

  assign drop_inc = bus.pressed_en && !absorb
                    && (!in_rng || (!dup && (cnt_rm == DEPTH_C)));

  // Saturating count of presses lost to a full queue or a bad floor code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_elevator_req_queue.sv
// Directed bench for elevator_req_queue: default 4-floor queue plus
// an 8-floor, 3-deep instance for full/out-of-range cases.
module tb_elevator_req_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  elevator_req_queue_if #(.LVL_W(2)) b1 ();
  elevator_req_queue_if #(.LVL_W(4)) b2 ();

  logic [2:0] count1;
  logic       full1;
  logic       empty1;
  logic [3:0] liq1;
  logic [1:0] count2;
  logic       full2;
  logic       empty2;
  logic [7:0] liq2;
`ifdef ELEVQ_DROP_CNT_EN
  logic       clr1 = 1'b0;
  logic       clr2 = 1'b0;
  logic [7:0] drop1;
  logic [7:0] drop2;
`endif

  elevator_req_queue u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (b1),
    .count        (count1),
    .full         (full1),
    .empty        (empty1),
    .lvl_in_queue (liq1)
`ifdef ELEVQ_DROP_CNT_EN
    ,
    .drop_clr     (clr1),
    .drop_cnt     (drop1)
`endif
  );

  elevator_req_queue #(
    .NUM_LVL (8),
    .LVL_W   (4),
    .DEPTH   (3),
    .CNT_W   (2)
  ) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (b2),
    .count        (count2),
    .full         (full2),
    .empty        (empty2),
    .lvl_in_queue (liq2)
`ifdef ELEVQ_DROP_CNT_EN
    ,
    .drop_clr     (clr2),
    .drop_cnt     (drop2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b1.pressed_en = 1'b0;
    b1.pos_valid  = 1'b0;
    b2.pressed_en = 1'b0;
    b2.pos_valid  = 1'b0;
  endtask

  task automatic press1(input logic [1:0] lvl);
    b1.pressed_en  = 1'b1;
    b1.pressed_lvl = lvl;
    tick();
    b1.pressed_en  = 1'b0;
  endtask

  task automatic press2(input logic [3:0] lvl);
    b2.pressed_en  = 1'b1;
    b2.pressed_lvl = lvl;
    tick();
    b2.pressed_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    b1.pressed_lvl = '0;
    b1.pos_lvl     = '0;
    b2.pressed_lvl = '0;
    b2.pos_lvl     = '0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({count1, full1, empty1, liq1} !== {3'd0, 1'b0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL reset_status got cnt=%0d full=%b empty=%b liq=%b want 0 0 1 0000",
               count1, full1, empty1, liq1);
    end
    checks++;
    if ({b1.target_valid, b1.target_lvl, b1.stop_at_pos_lvl} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_target got tv=%b tl=%0d stop=%b want 0 0 0",
               b1.target_valid, b1.target_lvl, b1.stop_at_pos_lvl);
    end
`ifdef ELEVQ_DROP_CNT_EN
    checks++;
    if (drop2 !== 8'd0) begin
      failures++;
      $display("FAIL reset_drop got %0d want 0", drop2);
    end
`endif
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    press1(2'd3);
    checks++;
    if ({count1, b1.target_valid, b1.target_lvl} !== {3'd1, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL fill_first got cnt=%0d tv=%b tl=%0d want 1 1 3",
               count1, b1.target_valid, b1.target_lvl);
    end
    press1(2'd0);
    press1(2'd2);
    checks++;
    if ({count1, b1.target_lvl, liq1, empty1} !== {3'd3, 2'd3, 4'b1101, 1'b0}) begin
      failures++;
      $display("FAIL fill_three got cnt=%0d tl=%0d liq=%b empty=%b want 3 3 1101 0",
               count1, b1.target_lvl, liq1, empty1);
    end
  endtask

  task automatic test_remove();
    b1.pos_valid = 1'b1;
    b1.pos_lvl   = 2'd0;
    tick();
    b1.pos_valid = 1'b0;
    checks++;
    if ({count1, liq1, b1.target_lvl, b1.stop_at_pos_lvl}
        !== {3'd2, 4'b1100, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL remove_mid got cnt=%0d liq=%b tl=%0d stop=%b want 2 1100 3 1",
               count1, liq1, b1.target_lvl, b1.stop_at_pos_lvl);
    end
    tick();
    checks++;
    if (b1.stop_at_pos_lvl !== 1'b0) begin
      failures++;
      $display("FAIL remove_pulse_end got stop=%b want 0", b1.stop_at_pos_lvl);
    end
  endtask

  task automatic test_dup_absorb();
    press1(2'd2);
    checks++;
    if ({count1, liq1, b1.stop_at_pos_lvl} !== {3'd2, 4'b1100, 1'b0}) begin
      failures++;
      $display("FAIL dup_press got cnt=%0d liq=%b stop=%b want 2 1100 0",
               count1, liq1, b1.stop_at_pos_lvl);
    end
    b1.pos_valid = 1'b1;
    b1.pos_lvl   = 2'd1;
    press1(2'd1);
    checks++;
    if ({count1, liq1, b1.stop_at_pos_lvl} !== {3'd2, 4'b1100, 1'b1}) begin
      failures++;
      $display("FAIL absorb_press got cnt=%0d liq=%b stop=%b want 2 1100 1",
               count1, liq1, b1.stop_at_pos_lvl);
    end
    tick();
    b1.pos_valid = 1'b0;
    checks++;
    if (b1.stop_at_pos_lvl !== 1'b0) begin
      failures++;
      $display("FAIL bare_pos got stop=%b want 0", b1.stop_at_pos_lvl);
    end
  endtask

  task automatic test_full_swap();
    do_reset();
    press1(2'd1);
    press1(2'd3);
    press1(2'd0);
    press1(2'd2);
    checks++;
    if ({count1, full1, b1.target_lvl, liq1} !== {3'd4, 1'b1, 2'd1, 4'b1111}) begin
      failures++;
      $display("FAIL full_fill got cnt=%0d full=%b tl=%0d liq=%b want 4 1 1 1111",
               count1, full1, b1.target_lvl, liq1);
    end
    b1.pos_valid = 1'b1;
    b1.pos_lvl   = 2'd3;
    press1(2'd3);
    checks++;
    if ({count1, full1, liq1, b1.stop_at_pos_lvl} !== {3'd3, 1'b0, 4'b0111, 1'b1}) begin
      failures++;
      $display("FAIL rm_absorb got cnt=%0d full=%b liq=%b stop=%b want 3 0 0111 1",
               count1, full1, liq1, b1.stop_at_pos_lvl);
    end
    b1.pos_lvl = 2'd0;
    press1(2'd3);
    b1.pos_valid = 1'b0;
    checks++;
    if ({count1, liq1, b1.target_lvl} !== {3'd3, 4'b1110, 2'd1}) begin
      failures++;
      $display("FAIL rm_add got cnt=%0d liq=%b tl=%0d want 3 1110 1",
               count1, liq1, b1.target_lvl);
    end
    b1.pos_valid = 1'b1;
    b1.pos_lvl   = 2'd1;
    tick();
    b1.pos_valid = 1'b0;
    checks++;
    if ({count1, b1.target_lvl, liq1} !== {3'd2, 2'd2, 4'b1100}) begin
      failures++;
      $display("FAIL head_pop got cnt=%0d tl=%0d liq=%b want 2 2 1100",
               count1, b1.target_lvl, liq1);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count1, empty1, full1, liq1, b1.target_valid, b1.target_lvl,
         b1.stop_at_pos_lvl} !== {3'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d empty=%b liq=%b tv=%b tl=%0d",
               count1, empty1, liq1, b1.target_valid, b1.target_lvl);
    end
    #2;
    rst_n = 1'b1;
    press1(2'd1);
    checks++;
    if ({count1, b1.target_lvl} !== {3'd1, 2'd1}) begin
      failures++;
      $display("FAIL post_reset_press got cnt=%0d tl=%0d want 1 1",
               count1, b1.target_lvl);
    end
  endtask

  task automatic test_drop();
    press2(4'd5);
    press2(4'd7);
    press2(4'd6);
    checks++;
    if ({count2, full2, b2.target_lvl} !== {2'd3, 1'b1, 4'd5}) begin
      failures++;
      $display("FAIL big_fill got cnt=%0d full=%b tl=%0d want 3 1 5",
               count2, full2, b2.target_lvl);
    end
    press2(4'd4);
    checks++;
    if ({count2, full2, liq2} !== {2'd3, 1'b1, 8'b1110_0000}) begin
      failures++;
      $display("FAIL full_reject got cnt=%0d full=%b liq=%b want 3 1 11100000",
               count2, full2, liq2);
    end
`ifdef ELEVQ_DROP_CNT_EN
    checks++;
    if (drop2 !== 8'd1) begin
      failures++;
      $display("FAIL drop_full got %0d want 1", drop2);
    end
`endif
    press2(4'd9);
    checks++;
    if ({count2, liq2} !== {2'd3, 8'b1110_0000}) begin
      failures++;
      $display("FAIL range_reject got cnt=%0d liq=%b want 3 11100000",
               count2, liq2);
    end
`ifdef ELEVQ_DROP_CNT_EN
    checks++;
    if (drop2 !== 8'd2) begin
      failures++;
      $display("FAIL drop_range got %0d want 2", drop2);
    end
    clr2 = 1'b1;
    press2(4'd9);
    clr2 = 1'b0;
    checks++;
    if (drop2 !== 8'd0) begin
      failures++;
      $display("FAIL drop_clr got %0d want 0", drop2);
    end
`endif
  endtask

  task automatic test_full_reuse();
    b2.pos_valid = 1'b1;
    b2.pos_lvl   = 4'd7;
    press2(4'd4);
    b2.pos_valid = 1'b0;
    checks++;
    if ({count2, full2, b2.target_lvl, liq2, b2.stop_at_pos_lvl}
        !== {2'd3, 1'b1, 4'd5, 8'b0111_0000, 1'b1}) begin
      failures++;
      $display("FAIL full_reuse got cnt=%0d full=%b tl=%0d liq=%b stop=%b",
               count2, full2, b2.target_lvl, liq2, b2.stop_at_pos_lvl);
    end
`ifdef ELEVQ_DROP_CNT_EN
    checks++;
    if (drop2 !== 8'd0) begin
      failures++;
      $display("FAIL reuse_no_drop got %0d want 0", drop2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_remove();
    test_dup_absorb();
    test_full_swap();
    test_async_reset();
    do_reset();
    test_drop();
    test_full_reuse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
